req_issue_queue: RTL

//  Upstream feeder for the ready/valid countdown stage. It buffers incoming tagged requests in a

---
 rtl/req_issue_queue_if.sv | 28 ++
 rtl/req_issue_queue.sv | 105 ++++++++++
 2 files changed

// File: rtl/req_issue_queue_if.sv
// Handshake bundle between a request producer/issue consumer (master) and
// the request issue queue (slave).
interface req_issue_queue_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic              issue_valid;
    logic              issue_ready;
    logic [DATA_W-1:0] issue_data;
    logic [OCC_W-1:0]  occupancy;
    logic              stall_timeout;
    logic              stall_clr;

    modport master (
        output req_valid, req_data, issue_ready, stall_clr,
        input  req_ready, issue_valid, issue_data, occupancy, stall_timeout
    );

    modport slave (
        input  req_valid, req_data, issue_ready, stall_clr,
        output req_ready, issue_valid, issue_data, occupancy, stall_timeout
    );
endinterface

// File: rtl/req_issue_queue.sv
// Tagged-request FIFO feeding a valid/ready issue port, with a sticky watchdog
// that flags issue-side stalls longer than the downstream busy window.
module req_issue_queue #(
    parameter int DATA_W   = 4,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 10
) (
    input  logic               clk,
    input  logic               rst,
    req_issue_queue_if.slave   q_if
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 2);

    localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              stall_q, stall_d;

    logic req_ready;
    logic issue_valid;
    logic push;
    logic pop;
    logic stalled;

    // Handshake flags come from registered state only, so a pop can never
    // open a push slot in the same cycle when the queue is full.
    assign req_ready   = (occ_q < OCC_FULL);
    assign issue_valid = (occ_q != '0);
    assign push        = q_if.req_valid & req_ready;
    assign pop         = issue_valid & q_if.issue_ready;
    assign stalled     = issue_valid & ~q_if.issue_ready;

    assign q_if.req_ready     = req_ready;
    assign q_if.issue_valid   = issue_valid;
    assign q_if.issue_data    = issue_valid ? mem_q[rd_ptr_q] : '0;
    assign q_if.occupancy     = occ_q;
    assign q_if.stall_timeout = stall_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        wait_cnt_d = wait_cnt_q;
        stall_d    = stall_q;

        // Pointers are exactly log2(DEPTH) bits, so wrap modulo DEPTH is free.
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (!issue_valid || pop) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_SAT) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        // Setting has priority over a coincident clear.
        if (stalled && (wait_cnt_q == WAIT_LIM)) begin
            stall_d = 1'b1;
        end else if (q_if.stall_clr) begin
            stall_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            wait_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

    // NOTE: storage is deliberately not reset; issue_data is masked while empty,
    // so stale contents are never observable and the array maps to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= q_if.req_data;
        end
    end
endmodule
